time_keeper: RTL and testbench
==============================

TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 100_000_000, giving clk cycles per second.
REQ-002 The module SHALL have input port clk, 1 bit, the single system clock.
REQ-003 The module SHALL have input port reset, 1 bit, synchronous and active-high.
REQ-004 The module SHALL have input port btn_mode, 1 bit, a debounced single-cycle pulse that advances the mode.
REQ-005 The module SHALL have input port btn_inc, 1 bit, a debounced single-cycle pulse that increments the selected field.
REQ-006 The module SHALL have output port out_num, 32 bits, packed BCD time: [3:0] sec units, [7:4] sec tens, [11:8] 0, [15:12] min units, [19:16] min tens, [23:20] 0, [27:24] hr units, [31:28] hr tens.
REQ-007 The module SHALL have output port clock_mode, 1 bit, tied to 1 so the separator digits show.
REQ-008 The module SHALL have output port dot_clk, 1 bit, the separator blink signal.
REQ-009 The module SHALL have output port turn_on, 1 bit, the display enable that blinks while a field is being set.
REQ-010 The module SHALL have output port tick_1hz, 1 bit, a one-cycle pulse issued once per counted second.
REQ-011 The module SHALL have output port pm, 1 bit, the PM flag (see Configuration).

Function
REQ-012 The module SHALL implement an FSM with states RUN, SET_HR and SET_MIN, transitioning RUN->SET_HR->SET_MIN->RUN, one step per btn_mode pulse.
REQ-013 The module SHALL implement a prescaler that counts 0..CLK_FREQ-1 and wraps, free-running in all states.
REQ-014 When prescaler==CLK_FREQ-1 in state RUN, the module SHALL, on the same edge, update the time registers and register tick_1hz=1 for exactly one cycle.
REQ-015 The module SHALL make the new out_num and tick_1hz visible in the same cycle, giving one cycle of latency from the prescaler terminal count.
REQ-016 In RUN, each tick SHALL increment the seconds in BCD; sec 59->00 SHALL carry to minutes; min 59->00 SHALL carry to hours; hr 23->00 SHALL wrap, so 23:59:59 becomes 00:00:00.
REQ-017 The module SHALL never produce a BCD nibble above 9 in any field.
REQ-018 On entering SET_HR, seconds SHALL be cleared to 00.
REQ-019 In SET_HR, btn_inc SHALL increment hours only, wrapping 23->00 with no other effect.
REQ-020 In SET_MIN, btn_inc SHALL increment minutes only, wrapping 59->00 with no carry to hours.
REQ-021 In SET_HR and SET_MIN, tick_1hz SHALL stay 0 and the time SHALL not advance.
REQ-022 On the SET_MIN->RUN transition, the prescaler SHALL clear to 0, so the first tick arrives exactly CLK_FREQ cycles later.
REQ-023 When btn_mode and btn_inc are high in the same cycle, btn_mode SHALL take effect and btn_inc SHALL be ignored.
REQ-024 btn_inc in RUN SHALL be ignored.
REQ-025 dot_clk SHALL be 1 while prescaler < CLK_FREQ/2 and 0 otherwise in RUN, and constant 1 in the SET states.
REQ-026 turn_on SHALL be 1 in RUN; in the SET states it SHALL be 1 while prescaler < CLK_FREQ/2 and 0 otherwise.

Reset
REQ-027 When reset is high, on the next clk edge the module SHALL set: state RUN, prescaler 0, out_num 32'h0 (00:00:00), tick_1hz 0, dot_clk 1, turn_on 1, pm 0.
REQ-028 Reset asserted mid-SET or mid-carry SHALL override every other input in that cycle.

Configuration
REQ-029 With CLOCK_12H_EN defined, the hour field SHALL run 12,01..11 and reset to 12 with pm=0.
REQ-030 With CLOCK_12H_EN defined, the 11->12 hour step (carry or btn_inc) SHALL toggle pm, and SET_HR SHALL wrap 12->01.
REQ-031 Without CLOCK_12H_EN, the module SHALL use 24-hour behaviour as above, with pm tied to 0.

Structure
REQ-032 A package time_keeper_pkg SHALL hold the state enum (RUN, SET_HR, SET_MIN), the BCD field limits (59, 23, 12) and the field bit offsets within out_num.
REQ-033 A sub-module bcd_mod_counter SHALL implement a two-digit BCD counter with inc, load-zero, parameterised MAX/MIN value, and carry-out on wrap, instantiated for seconds, minutes and hours.
REQ-034 The time_keeper top SHALL hold the FSM, the prescaler and the output registers.

Verification (CLK_FREQ=10)
REQ-035 Reset then 10 cycles -> tick_1hz pulses once at cycle 10, out_num=32'h00000001.
REQ-036 Preload 23:59:59 via SET, then RUN and one tick -> out_num=32'h0, tick_1hz high exactly one cycle.
REQ-037 Set 00:59:58, run 2 ticks -> 32'h01000000, then minutes/hours carry correct with nibbles [11:8] and [23:20] equal to 0.
REQ-038 In SET_MIN at 59, btn_inc -> minutes 00, hours unchanged; simultaneous btn_mode+btn_inc in SET_HR -> SET_MIN, hours unchanged.
REQ-039 In SET_HR, observe turn_on toggle with period 10 cycles (5 high/5 low) and dot_clk constant 1; assert reset mid-SET -> RUN, 00:00:00, turn_on=1 next cycle.
REQ-040 With CLOCK_12H_EN, run from 11:59:59 -> 12:00:00 with pm=1; SET_HR at 12 plus btn_inc -> 01.

Source files
------------

// File: rtl/time_keeper_pkg.sv
// Shared types and constants for the time_keeper clock block.
// Holds the mode FSM states, BCD field limits and field positions within out_num.
package time_keeper_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_t;

    localparam logic [7:0] SEC_MAX_BCD    = 8'h59;
    localparam logic [7:0] MIN_MAX_BCD    = 8'h59;
    localparam logic [7:0] HR_MAX_24_BCD  = 8'h23;
    localparam logic [7:0] HR_MAX_12_BCD  = 8'h12;
    localparam logic [7:0] HR_MIN_12_BCD  = 8'h01;
    localparam logic [7:0] HR_ELEVEN_BCD  = 8'h11;

    localparam int SEC_OFS = 0;
    localparam int MIN_OFS = 12;
    localparam int HR_OFS  = 24;

    // Spare nibbles [11:8] and [23:20] stay zero so the display shows blank separators.
    function automatic logic [31:0] packTime(input logic [7:0] hr,
                                             input logic [7:0] mins,
                                             input logic [7:0] sec);
        logic [31:0] packed_time;
        packed_time = '0;
        packed_time[HR_OFS  +: 8] = hr;
        packed_time[MIN_OFS +: 8] = mins;
        packed_time[SEC_OFS +: 8] = sec;
        return packed_time;
    endfunction

endpackage

// File: rtl/time_keeper_counter.sv
// Two-digit BCD modulo counter used for the seconds, minutes and hours fields.
// Wraps from MAX_BCD to MIN_BCD; load-zero has priority over increment.
module bcd_mod_counter #(
    parameter logic [7:0] MAX_BCD = 8'h59,
    parameter logic [7:0] MIN_BCD = 8'h00,
    parameter logic [7:0] RST_BCD = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_inc,
    input  logic       i_clr,
    output logic [7:0] o_value,
    output logic       o_carry
);

    logic [7:0] r_value;
    logic [7:0] w_next;
    logic       w_atMax;

    assign w_atMax = (r_value == MAX_BCD);
    assign o_carry = i_inc && !i_clr && w_atMax;
    assign o_value = r_value;

    always_comb begin
        w_next = r_value;
        if (w_atMax)
            w_next = MIN_BCD;
        else if (r_value[3:0] == 4'd9)
            w_next = {r_value[7:4] + 4'd1, 4'd0};
        else
            w_next = {r_value[7:4], r_value[3:0] + 4'd1};
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_value <= RST_BCD;
        else if (i_clr)
            r_value <= 8'h00;
        else if (i_inc)
            r_value <= w_next;
    end

endmodule

// File: rtl/time_keeper.sv
// BCD wall clock with RUN / SET_HR / SET_MIN modes, 1 Hz prescaler and display controls.
// Define CLOCK_12H_EN for a 12-hour clock (12,01..11) with a PM flag; otherwise 24-hour.
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    output logic [31:0] out_num,
    output logic        clock_mode,
    output logic        dot_clk,
    output logic        turn_on,
    output logic        tick_1hz,
    output logic        pm
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PRESC_TERM = PW'(CLK_FREQ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_FREQ / 2);

`ifdef CLOCK_12H_EN
    localparam logic [7:0] HR_MAX = HR_MAX_12_BCD;
    localparam logic [7:0] HR_MIN = HR_MIN_12_BCD;
    localparam logic [7:0] HR_RST = HR_MAX_12_BCD;
`else
    localparam logic [7:0] HR_MAX = HR_MAX_24_BCD;
    localparam logic [7:0] HR_MIN = 8'h00;
    localparam logic [7:0] HR_RST = 8'h00;
`endif

    state_t        r_state;
    state_t        w_nextState;
    logic [PW-1:0] r_presc;
    logic          r_tick;
    logic          w_tick;
    logic          w_incEff;
    logic          w_secClr;
    logic          w_secCarry;
    logic          w_minInc;
    logic          w_minCarry;
    logic          w_hrInc;
    logic          w_unusedHrCarry;
    logic          w_firstHalf;
    logic [7:0]    w_sec;
    logic [7:0]    w_min;
    logic [7:0]    w_hr;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= RUN;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (btn_mode) begin
            case (r_state)
                RUN:     w_nextState = SET_HR;
                SET_HR:  w_nextState = SET_MIN;
                SET_MIN: w_nextState = RUN;
                default: w_nextState = RUN;
            endcase
        end
    end

    // Returning to RUN restarts the second so the first tick lands a full period later.
    always_ff @(posedge clk) begin
        if (reset)
            r_presc <= '0;
        else if ((r_state == SET_MIN) && btn_mode)
            r_presc <= '0;
        else if (r_presc == PRESC_TERM)
            r_presc <= '0;
        else
            r_presc <= r_presc + PW'(1);
    end

    assign w_tick   = (r_state == RUN) && (r_presc == PRESC_TERM);
    assign w_incEff = btn_inc && !btn_mode;
    assign w_secClr = (r_state == RUN) && btn_mode;
    assign w_minInc = w_secCarry || ((r_state == SET_MIN) && w_incEff);
    assign w_hrInc  = ((r_state == RUN) && w_minCarry) || ((r_state == SET_HR) && w_incEff);

    bcd_mod_counter #(.MAX_BCD(SEC_MAX_BCD), .MIN_BCD(8'h00), .RST_BCD(8'h00)) u_sec (
        .clk(clk), .reset(reset), .i_inc(w_tick), .i_clr(w_secClr),
        .o_value(w_sec), .o_carry(w_secCarry)
    );

    bcd_mod_counter #(.MAX_BCD(MIN_MAX_BCD), .MIN_BCD(8'h00), .RST_BCD(8'h00)) u_min (
        .clk(clk), .reset(reset), .i_inc(w_minInc), .i_clr(1'b0),
        .o_value(w_min), .o_carry(w_minCarry)
    );

    bcd_mod_counter #(.MAX_BCD(HR_MAX), .MIN_BCD(HR_MIN), .RST_BCD(HR_RST)) u_hr (
        .clk(clk), .reset(reset), .i_inc(w_hrInc), .i_clr(1'b0),
        .o_value(w_hr), .o_carry(w_unusedHrCarry)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_tick <= 1'b0;
        else
            r_tick <= w_tick;
    end

`ifdef CLOCK_12H_EN
    logic r_pm;

    // Stepping 11 -> 12 crosses noon/midnight, whether by carry or by a set press.
    always_ff @(posedge clk) begin
        if (reset)
            r_pm <= 1'b0;
        else if (w_hrInc && (w_hr == HR_ELEVEN_BCD))
            r_pm <= ~r_pm;
    end

    assign pm = r_pm;
`else
    assign pm = 1'b0;
`endif

    assign w_firstHalf = (r_presc < PRESC_HALF);
    assign out_num     = packTime(w_hr, w_min, w_sec);
    assign tick_1hz    = r_tick;
    assign clock_mode  = 1'b1;
    assign dot_clk     = (r_state == RUN) ? w_firstHalf : 1'b1;
    assign turn_on     = (r_state == RUN) ? 1'b1 : w_firstHalf;

endmodule

// File: tb/tb_time_keeper.sv
// Directed self-checking bench for time_keeper at CLK_FREQ=10.
// Common checks run in both builds; 24-hour and CLOCK_12H_EN checks are selected by the macro.
module tb_time_keeper;

    localparam int CF = 10;
`ifdef CLOCK_12H_EN
    localparam logic [31:0] RST_NUM = 32'h12000000;
`else
    localparam logic [31:0] RST_NUM = 32'h00000000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic [31:0] out_num;
    logic        clock_mode;
    logic        dot_clk;
    logic        turn_on;
    logic        tick_1hz;
    logic        pm;

    int vecCount = 0;
    int missCount = 0;

    time_keeper #(.CLK_FREQ(CF)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .out_num(out_num), .clock_mode(clock_mode), .dot_clk(dot_clk),
        .turn_on(turn_on), .tick_1hz(tick_1hz), .pm(pm)
    );

    always #5 clk = ~clk;

    // Every step lands 1 time unit after a rising edge, where outputs are stable.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic mode, input logic inc);
        btn_mode = mode;
        btn_inc  = inc;
        cycle();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic pressInc(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1);
    endtask

    // From RUN with minutes at 00: press hours hrPresses times, minutes minPresses times.
    task automatic setTime(input int hrPresses, input int minPresses);
        applyStimulus(1'b1, 1'b0);
        pressInc(hrPresses);
        applyStimulus(1'b1, 1'b0);
        pressInc(minPresses);
        applyStimulus(1'b1, 1'b0);
    endtask

    task automatic runTicks(input int n);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < n * CF + 20) begin
            cycle();
            cyc++;
            if (tick_1hz) seen++;
        end
        checkOutput("tick_count", seen, n);
    endtask

    task automatic cyclesToTick(output int cyc);
        cyc = 0;
        do begin
            cycle();
            cyc++;
        end while (!tick_1hz && cyc < 3 * CF);
    endtask

    initial begin
        int tickSeen;
        int highCount;
        int dotLow;
        int cyc;
        logic [31:0] held;

        // Reset state
        doReset();
        checkOutput("rst_num", out_num, RST_NUM);
        checkOutput("rst_tick", {31'b0, tick_1hz}, 32'd0);
        checkOutput("rst_dot", {31'b0, dot_clk}, 32'd1);
        checkOutput("rst_turn_on", {31'b0, turn_on}, 32'd1);
        checkOutput("rst_pm", {31'b0, pm}, 32'd0);
        checkOutput("clock_mode", {31'b0, clock_mode}, 32'd1);

        // First second: tick on the 10th edge after reset, dot blinks on the half second
        tickSeen = 0;
        for (int i = 1; i <= CF; i++) begin
            cycle();
            if (i < CF && tick_1hz) tickSeen++;
            if (i == 4) checkOutput("dot_first_half", {31'b0, dot_clk}, 32'd1);
            if (i == 5) checkOutput("dot_second_half", {31'b0, dot_clk}, 32'd0);
            if (i == 7) checkOutput("run_turn_on", {31'b0, turn_on}, 32'd1);
        end
        checkOutput("tick_early", tickSeen, 0);
        checkOutput("tick_at_10", {31'b0, tick_1hz}, 32'd1);
        checkOutput("first_second", out_num, RST_NUM | 32'h1);
        cycle();
        checkOutput("tick_one_cycle", {31'b0, tick_1hz}, 32'd0);

        // btn_inc ignored in RUN, then SET_HR clears seconds and freezes time
        applyStimulus(1'b0, 1'b1);
        checkOutput("run_inc_ignored", out_num, RST_NUM | 32'h1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("set_hr_sec_clr", out_num, RST_NUM);
        highCount = 0;
        dotLow = 0;
        tickSeen = 0;
        for (int i = 0; i < 2 * CF; i++) begin
            cycle();
            if (turn_on) highCount++;
            if (!dot_clk) dotLow++;
            if (tick_1hz) tickSeen++;
        end
        checkOutput("set_turn_on_duty", highCount, CF);
        checkOutput("set_dot_const", dotLow, 0);
        checkOutput("set_no_tick", tickSeen, 0);
        checkOutput("set_time_frozen", out_num, RST_NUM);
        pressInc(3);
        checkOutput("set_hr_3", out_num, 32'h03000000);

        // Reset mid-SET with both buttons held
        reset = 1'b1;
        btn_mode = 1'b1;
        btn_inc = 1'b1;
        cycle();
        reset = 1'b0;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        checkOutput("midset_rst_num", out_num, RST_NUM);
        checkOutput("midset_rst_turn_on", {31'b0, turn_on}, 32'd1);
        checkOutput("midset_rst_dot", {31'b0, dot_clk}, 32'd1);
        cyclesToTick(cyc);
        checkOutput("midset_rst_running", cyc, CF);

`ifdef CLOCK_12H_EN
        // 12-hour: 12 -> 01 in SET_HR, and 11:59:59 -> 12:00:00 sets pm
        doReset();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("h12_set_wrap", out_num, 32'h01000000);
        pressInc(10);
        applyStimulus(1'b1, 1'b0);
        pressInc(59);
        applyStimulus(1'b1, 1'b0);
        checkOutput("h12_preset", out_num, 32'h11059000);
        runTicks(59);
        checkOutput("h12_1159_59", out_num, 32'h11059059);
        checkOutput("h12_am", {31'b0, pm}, 32'd0);
        runTicks(1);
        checkOutput("h12_noon", out_num, 32'h12000000);
        checkOutput("h12_pm", {31'b0, pm}, 32'd1);
`else
        // Hour wrap in SET_HR, mode+inc priority, minute wrap without hour carry
        doReset();
        applyStimulus(1'b1, 1'b0);
        pressInc(24);
        checkOutput("set_hr_wrap", out_num, 32'h00000000);
        pressInc(23);
        checkOutput("set_hr_23", out_num, 32'h23000000);
        applyStimulus(1'b1, 1'b1);
        checkOutput("mode_beats_inc", out_num, 32'h23000000);
        pressInc(59);
        checkOutput("set_min_59", out_num, 32'h23059000);
        applyStimulus(1'b0, 1'b1);
        checkOutput("set_min_wrap", out_num, 32'h23000000);
        pressInc(59);
        applyStimulus(1'b1, 1'b0);
        cyclesToTick(cyc);
        checkOutput("resume_latency", cyc, CF);
        checkOutput("resume_first", out_num, 32'h23059001);
        runTicks(58);
        checkOutput("pre_midnight", out_num, 32'h23059059);
        runTicks(1);
        checkOutput("midnight", out_num, 32'h00000000);
        checkOutput("midnight_tick", {31'b0, tick_1hz}, 32'd1);
        cycle();
        checkOutput("midnight_tick_gone", {31'b0, tick_1hz}, 32'd0);

        // Minute/hour carries from 00:59:58 and 09:59:00
        doReset();
        setTime(0, 59);
        runTicks(58);
        checkOutput("t_005958", out_num, 32'h00059058);
        runTicks(1);
        checkOutput("t_005959", out_num, 32'h00059059);
        runTicks(1);
        held = out_num;
        checkOutput("t_010000", held, 32'h01000000);
        checkOutput("spare_nibbles", {24'b0, held[23:20], held[11:8]}, 32'd0);
        doReset();
        setTime(9, 59);
        runTicks(60);
        checkOutput("t_100000", out_num, 32'h10000000);
        checkOutput("pm_tied_low", {31'b0, pm}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
